// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
// Shared definitions for the perceptron sample store: Q-format scaling,
// default geometry and the burst-engine state encoding.
// -----------------------------------------------------------------------------
package perceptron_pkg;

  // Samples are Q6.9: real value = raw / 2**FRAC_BITS.
  localparam int FRAC_BITS  = 9;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_NUM_CH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } stream_state_e;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perceptron_sample_stream_mem_if.sv
// -----------------------------------------------------------------------------
// perceptron_sample_stream_mem_if
// Output beat stream of the sample store (valid/ready handshake).
//   out_valid : beat valid (source -> sink)
//   out_ready : sink accepts beat (sink -> source)
//   out_data  : all channels of one sample index, channel c at [c*DATA_W +: DATA_W]
//   out_last  : final beat of the burst
// -----------------------------------------------------------------------------
interface perceptron_sample_stream_mem_if
  import perceptron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
);

  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/sample_ram_sp.sv
// -----------------------------------------------------------------------------
// sample_ram_sp
// One channel of sample storage: synchronous RAM, one-cycle read latency,
// read-before-write when the read and write hit the same address.
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read strobe
//   i_rd_addr : read address
//   o_rd_data : read data, valid the cycle after i_rd_en
// -----------------------------------------------------------------------------
module sample_ram_sp
  import perceptron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage array and read register; non-blocking update gives old data on collision.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/perceptron_sample_stream_mem.sv
// -----------------------------------------------------------------------------
// perceptron_sample_stream_mem
// Multi-channel sample store with a host write port and a burst engine that
// streams a contiguous (wrapping) address range, one beat per sample index.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en/wr_ch/wr_addr/wr_data : host write; wr_ch >= NUM_CH is dropped
//   start/start_addr/count      : burst request (count 1..DEPTH)
//   abort               : cancel the running burst, no done pulse
//   busy                : burst in progress
//   done                : one-cycle pulse after the last beat (or a rejected start)
//   out_if              : beat stream (valid/ready/data/last)
// -----------------------------------------------------------------------------
module perceptron_sample_stream_mem
  import perceptron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  perceptron_sample_stream_mem_if.master out_if
);

  localparam int              BUS_W   = NUM_CH * DATA_W;
  localparam logic [ADDR_W:0] L_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  stream_state_e     r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_issue_left;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_out_valid;
  logic              r_out_last;
  logic [BUS_W-1:0]  r_out_data;
  logic              r_skid_valid;
  logic              r_skid_last;
  logic [BUS_W-1:0]  r_skid_data;
  logic              r_busy;
  logic              r_done;

  logic [BUS_W-1:0]  w_rd_data;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic              w_slot_free;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_issue_addr;

  // One RAM per channel; all channels share the burst read address.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_we;
    assign w_we = wr_en && (wr_ch == CH_W'(c));

    sample_ram_sp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_we),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_rd_en   (w_issue),
      .i_rd_addr (w_issue_addr),
      .o_rd_data (w_rd_data[c*DATA_W +: DATA_W])
    );
  end

  // Read-issue decision: the first read goes out in the accepted start cycle so
  // that data is registered at the output two cycles after start.
  always_comb begin
    w_start_ok   = 1'b0;
    w_start_bad  = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = r_rd_addr;
    w_pop        = r_out_valid && out_if.out_ready;
    // Entries held or owed after this cycle: output reg + skid + in-flight read.
    w_occ        = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_inflight) - 2'(w_pop);
    w_slot_free  = (w_occ < 2'd2);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((count != L_ZERO) && (count <= L_DEPTH)) begin
            w_start_ok   = 1'b1;
            w_issue      = 1'b1;
            w_issue_addr = start_addr;
            w_issue_last = (count == L_ONE);
          end else begin
            w_start_bad  = 1'b1;
          end
        end else begin
          w_start_ok = 1'b0;
        end
      end
      ST_STREAM: begin
        if (!abort && w_slot_free) begin
          w_issue      = 1'b1;
          w_issue_last = (r_issue_left == L_ONE);
        end else begin
          w_issue = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_issue = 1'b0;
      end
      default: begin
        w_issue = 1'b0;
      end
    endcase
  end

  // Burst FSM, skid buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_rd_addr       <= '0;
      r_issue_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_last      <= 1'b0;
      r_out_data      <= '0;
      r_skid_valid    <= 1'b0;
      r_skid_last     <= 1'b0;
      r_skid_data     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Output register refills from skid first (keeps order), then from the RAM.
      if (!r_out_valid || w_pop) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_last   <= r_skid_last;
          r_skid_valid <= r_inflight;
          r_skid_data  <= w_rd_data;
          r_skid_last  <= r_inflight_last;
        end else if (r_inflight) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= w_rd_data;
          r_out_last   <= r_inflight_last;
        end else begin
          r_out_valid  <= 1'b0;
        end
      end else if (r_inflight) begin
        // Stalled: the issue rule guarantees the skid slot is free here.
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_rd_data;
        r_skid_last  <= r_inflight_last;
      end

      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      if (w_issue) begin
        r_rd_addr <= w_issue_addr + ADDR_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_busy       <= 1'b1;
            r_issue_left <= count - L_ONE;
            r_state      <= (count == L_ONE) ? ST_DRAIN : ST_STREAM;
          end else if (w_start_bad) begin
            r_done <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (abort) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_inflight   <= 1'b0;
          end else if (w_issue) begin
            r_issue_left <= r_issue_left - L_ONE;
            if (r_issue_left == L_ONE) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_inflight   <= 1'b0;
          end else if (w_pop && r_out_last) begin
            // Last beat is always the youngest entry, so the buffer is now empty.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_valid = r_out_valid;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_last  = r_out_last;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_perceptron_sample_stream_mem.sv
// -----------------------------------------------------------------------------
// tb_perceptron_sample_stream_mem
// Directed + randomized bench for the sample store. Expected beats come from a
// plain array image of the memory updated on every accepted host write.
// -----------------------------------------------------------------------------
module tb_perceptron_sample_stream_mem;
  import perceptron_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CH_W   = ch_width(NUM_CH);
  localparam int BUS_W  = NUM_CH * DATA_W;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   count;
  logic              abort;
  logic              busy;
  logic              done;

  int n_vec;
  int n_miss;

  logic [DATA_W-1:0] mem_m [NUM_CH][DEPTH];

  perceptron_sample_stream_mem_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) sif ();

  perceptron_sample_stream_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .out_if     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BUS_W-1:0] beat_of(input int a);
    logic [BUS_W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = mem_m[c][a % DEPTH];
    return v;
  endfunction

  task automatic write_word(input int ch, input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (ch < NUM_CH) mem_m[ch][a] = d;
  endtask

  // Runs one burst; abort_beat >= 0 aborts while that beat index is presented.
  task automatic run_burst(input string tag, input int sa, input int cnt, input bit rand_rdy,
                           input int abort_beat, input bit poke_start, input bit check_lat);
    logic [BUS_W-1:0] exp_q [$];
    logic [BUS_W-1:0] prev_data;
    logic prev_last, prev_stall, rdy, fin;
    int beat, cyc, first_valid, last_cyc, n_exp;
    for (int i = 0; i < cnt; i++) exp_q.push_back(beat_of(sa + i));
    n_exp = (abort_beat >= 0) ? abort_beat + 1 : cnt;
    start = 1'b1; start_addr = ADDR_W'(sa % DEPTH); count = (ADDR_W+1)'(cnt);
    sif.out_ready = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    beat = 0; cyc = 1; first_valid = -1; last_cyc = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      if (prev_stall) begin
        check({tag, " hold_valid"}, 64'(sif.out_valid), 64'd1);
        check({tag, " hold_data"}, 64'(sif.out_data), 64'(prev_data));
        check({tag, " hold_last"}, 64'(sif.out_last), 64'(prev_last));
      end
      check({tag, " no_early_done"}, 64'(done), 64'd0);
      if (sif.out_valid && first_valid < 0) first_valid = cyc;
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_beat == beat && sif.out_valid) begin
        abort = 1'b1;
        rdy = 1'b1;
      end
      sif.out_ready = rdy;
      if (poke_start && cyc == 3) begin
        start = 1'b1; start_addr = '0; count = (ADDR_W+1)'(3);
      end
      if (sif.out_valid && rdy) begin
        check({tag, " beat_data"}, 64'(sif.out_data), 64'(exp_q[beat]));
        check({tag, " beat_last"}, 64'(sif.out_last), 64'(beat == cnt - 1));
        beat++;
        last_cyc = cyc;
      end
      prev_stall = sif.out_valid && !rdy;
      prev_data  = sif.out_data;
      prev_last  = sif.out_last;
      if (abort) begin
        tick();
        abort = 1'b0;
        check({tag, " abort_valid"}, 64'(sif.out_valid), 64'd0);
        check({tag, " abort_busy"}, 64'(busy), 64'd0);
        check({tag, " abort_done"}, 64'(done), 64'd0);
        tick();
        check({tag, " abort_done2"}, 64'(done), 64'd0);
        fin = 1'b1;
      end else if (beat == cnt) begin
        tick();
        start = 1'b0;
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " valid_at_done"}, 64'(sif.out_valid), 64'd0);
        tick();
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        fin = 1'b1;
      end else begin
        tick();
        start = 1'b0;
        cyc++;
      end
    end
    check({tag, " beats"}, 64'(beat), 64'(n_exp));
    if (check_lat) begin
      check({tag, " first_valid_cycle"}, 64'(first_valid), 64'd2);
      check({tag, " last_beat_cycle"}, 64'(last_cyc), 64'(2 + cnt - 1));
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; count = '0; abort = 1'b0; sif.out_ready = 1'b0;
    #2;
    check("rst busy", 64'(busy), 64'd0);
    check("rst valid", 64'(sif.out_valid), 64'd0);
    check("rst last", 64'(sif.out_last), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst data", 64'(sif.out_data), 64'd0);
    #6 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) begin
      write_word(0, k, 16'(k));
      write_word(1, k, 16'(k << FRAC_BITS));
      write_word(2, k, 16'($urandom));
    end
    for (int a = 20; a < 36; a++)
      for (int c = 0; c < NUM_CH; c++) write_word(c, a, 16'($urandom));
    for (int a = DEPTH - 2; a < DEPTH; a++)
      for (int c = 0; c < NUM_CH; c++) write_word(c, a, 16'($urandom));

    run_burst("full", 2, 5, 1'b0, -1, 1'b0, 1'b1);
    run_burst("wrap", DEPTH - 2, 4, 1'b0, -1, 1'b0, 1'b0);
    run_burst("bp", 20, 16, 1'b1, -1, 1'b1, 1'b0);
    run_burst("abort", 0, 8, 1'b0, 2, 1'b0, 1'b0);

    // Rejected starts: only a done pulse.
    start = 1'b1; start_addr = ADDR_W'(3); count = '0;
    tick();
    start = 1'b0;
    check("cnt0 done", 64'(done), 64'd1);
    check("cnt0 busy", 64'(busy), 64'd0);
    check("cnt0 valid", 64'(sif.out_valid), 64'd0);
    tick();
    check("cnt0 done_pulse", 64'(done), 64'd0);
    start = 1'b1; count = (ADDR_W+1)'(DEPTH + 1);
    tick();
    start = 1'b0;
    check("cntbig done", 64'(done), 64'd1);
    check("cntbig busy", 64'(busy), 64'd0);
    tick();

    // Write to ch1[5] in the cycle address 5 is read: the beat carries old data.
    wr_en = 1'b1; wr_ch = CH_W'(1); wr_addr = ADDR_W'(5); wr_data = 16'h1234;
    run_burst("coll", 5, 1, 1'b0, -1, 1'b0, 1'b0);
    mem_m[1][5] = 16'h1234;
    run_burst("reread", 5, 1, 1'b0, -1, 1'b0, 1'b0);
    write_word(NUM_CH, 5, 16'hDEAD);
    run_burst("drop", 5, 1, 1'b0, -1, 1'b0, 1'b0);

    // Reset while a beat is being presented.
    sif.out_ready = 1'b1;
    start = 1'b1; start_addr = '0; count = (ADDR_W+1)'(8);
    tick();
    start = 1'b0;
    tick();
    check("prerst valid", 64'(sif.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", 64'(sif.out_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("postrst busy", 64'(busy), 64'd0);
    run_burst("post_rst", 0, 6, 1'b1, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/perceptron_sample_stream_mem.md
Name: perceptron_sample_stream_mem

Overview:
Parametrised multi-channel sample store for the perceptron datapath. It holds NUM_CH feature channels (x1, x2, ...) of DATA_W-bit fixed-point samples, DEPTH entries each.
- A host write port loads samples one channel at a time.
- A burst engine streams a contiguous address range. Each beat carries all channels of one sample index, delivered over a valid/ready handshake to the MAC/activation stage.
- Replaces the single-channel, fixed 1024x16 single-port store with a streaming, back-pressure-aware block.

Parameters:
- DATA_W, 16, sample width (Q6.9 fixed point, i.e. real value times 512).
- DEPTH, 1024, entries per channel; power of two.
- NUM_CH, 2, number of feature channels.
- ADDR_W, $clog2(DEPTH), address width (derived).
- CH_W, max(1,$clog2(NUM_CH)), channel select width (derived).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_ch  in  CH_W  channel to write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- start  in  1  burst request pulse.
- start_addr  in  ADDR_W  first sample index of the burst.
- count  in  ADDR_W+1  number of beats, 1..DEPTH.
- abort  in  1  cancel the current burst.
- busy  out  1  burst in progress.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  NUM_CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W].
- out_last  out  1  final beat of the burst.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy=0, out_valid=0, out_last=0, done=0, out_data=0.
  - FSM goes to IDLE; pointers, counters and skid buffer are cleared.
  - Memory array contents are not reset.
- Memory: one synchronous RAM per channel, one-cycle read latency.
- Write port:
  - wr_en=1 writes wr_data into channel wr_ch at wr_addr on the clock edge.
  - wr_ch >= NUM_CH: write is dropped.
  - Writes are accepted in every state.
  - Write and read to the same address in the same cycle: the read returns the old data (read-before-write).
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - start=1 with 1 <= count <= DEPTH latches start_addr and count, and moves to STREAM. busy=1 from the next cycle.
  - start with count=0 or count>DEPTH: no burst; done pulses on the next cycle.
- STREAM:
  - A read is issued each cycle the two-entry output skid buffer, plus the in-flight read, has a free slot.
  - Read address increments by one per issue and wraps modulo DEPTH (DEPTH-1 -> 0).
  - After `count` reads are issued, the FSM moves to DRAIN.
- DRAIN: stays until the buffer is empty and the last beat has handshaken, then goes to IDLE. done=1 for one cycle and busy=0 in that same cycle.
- Output handshake:
  - A beat transfers when out_valid && out_ready.
  - out_valid, out_data and out_last hold stable while out_valid && !out_ready.
  - No beat is lost or duplicated.
  - out_last=1 only on beat number `count`.
- Throughput and latency:
  - With out_ready held at 1: one beat per cycle.
  - First out_valid is 2 cycles after the start cycle: STREAM entry, then RAM latency.
- start while busy is ignored and has no effect.
- abort:
  - In any non-IDLE state: FSM goes to IDLE on the next edge, the buffer and in-flight read are flushed, out_valid=0 from the next cycle.
  - done is not pulsed.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.

Decomposition:
- Shared package perceptron_pkg: FRAC_BITS=9 (Q scaling 512), default DATA_W/DEPTH/NUM_CH, and an FSM state enum typedef.
- One sub-module sample_ram_sp: a single-channel, synchronous, read-before-write RAM, instantiated NUM_CH times in a generate loop.

Test Plan:
- Reset mid-burst: assert rst_n=0 during STREAM with out_valid=1 -> out_valid, busy and done are 0 immediately; the next burst after reset works.
- Full-rate burst: write ch0[k]=k and ch1[k]=k*512 for k=0..9. start_addr=2, count=5, out_ready=1 -> 5 consecutive beats (2,1024) ... (6,3072); out_last on the 5th beat; done one cycle later.
- Wrap-around: DEPTH=1024, start_addr=1022, count=4 -> beats come from addresses 1022, 1023, 0, 1 in order.
- Back-pressure: toggle out_ready randomly during count=16 -> all 16 beats arrive in order exactly once; out_data stays stable while stalled.
- Abort and degenerate cases:
  - abort on the 3rd beat of count=8 -> out_valid=0 next cycle, no done, busy=0.
  - start with count=0 -> done only.
  - start while busy -> ignored.
- Write collision: write ch1[5]=0x1234 in the same cycle the burst reads address 5 -> the beat carries the old value; a re-read returns 0x1234. Write with wr_ch=NUM_CH -> memory unchanged.
